lfsr_hex_display: RTL and testbench

- Parametrised LFSR pseudo-random generator with a built-in multi-digit hex 7-segment driver.
- Generalises the fixed 8-bit, two-digit LFSR-to-display path:
  - width and taps configurable;
  - run/step/load/hold modes;
  - clock-enable divider;
  - zero-seed lock-up protection;
  - period-completion detection.
- Sits between board inputs (switches/buttons) and the segment pins in the npc test tops.

---
 rtl/lfsr_disp_pkg.sv | 19 +
 rtl/hex7seg.sv | 12 +
 rtl/lfsr_hex_display.sv | 88 ++++++++
 tb/tb_lfsr_hex_display.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_disp_pkg.sv
// Shared encodings and the hex 7-segment font for the LFSR display block.
package lfsr_disp_pkg;

  localparam int unsigned SEG_W = 7;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Active-high patterns, bit6..0 = gfedcba, index = nibble value
  localparam logic [SEG_W-1:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7seg.sv
// One hex digit decoder: nibble to 7-segment pattern, optionally inverted.
module hex7seg
  import lfsr_disp_pkg::*;
(
  input  logic [3:0]       i_nibble,
  input  logic             i_active_low,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = HEX_FONT[i_nibble] ^ {SEG_W{i_active_low}};

endmodule

// File: rtl/lfsr_hex_display.sv
// Fibonacci LFSR with run/step/load/hold control, period detection and
// a registered multi-digit hex 7-segment output.
module lfsr_hex_display
  import lfsr_disp_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
  parameter int unsigned      DIV        = 4,
  parameter bit               ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic                        step,
  input  logic [WIDTH-1:0]            seed,
  output logic [WIDTH-1:0]            lfsr_out,
  output logic                        period_done,
  output logic [SEG_W*(WIDTH/4)-1:0]  hout
);

  localparam int unsigned DIGITS = WIDTH / 4;
  localparam int unsigned HOUT_W = SEG_W * DIGITS;
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [WIDTH-1:0]  r_state;
  logic [WIDTH-1:0]  r_ref;
  logic [DIV_W-1:0]  r_div;
  logic              r_step_q;
  logic              r_period;
  logic [HOUT_W-1:0] r_hout;

  mode_e             w_mode;
  logic              w_feedback;
  logic [WIDTH-1:0]  w_next;
  logic              w_tick;
  logic              w_step_rise;
  logic              w_advance;
  logic [WIDTH-1:0]  w_load_val;
  logic [HOUT_W-1:0] w_seg_c;

  // Advance conditions and the zero-seed guard
  always_comb begin
    w_mode      = mode_e'(mode);
    w_feedback  = ^(r_state & TAPS);
    w_next      = {r_state[WIDTH-2:0], w_feedback};
    w_tick      = (w_mode == MODE_RUN) && (r_div == DIV_W'(DIV - 1));
    w_step_rise = step & ~r_step_q;
    w_advance   = w_tick || ((w_mode == MODE_STEP) && w_step_rise);
    w_load_val  = (seed == '0) ? WIDTH'(1) : seed;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    hex7seg u_hex (
      .i_nibble     (r_state[4*k +: 4]),
      .i_active_low (ACTIVE_LOW),
      .o_seg_c      (w_seg_c[SEG_W*k +: SEG_W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RESET_SEED;
      r_ref    <= RESET_SEED;
      r_div    <= '0;
      r_step_q <= 1'b0;
      r_period <= 1'b0;
      r_hout   <= {HOUT_W{ACTIVE_LOW}};
    end else begin
      r_step_q <= step;
      r_div    <= ((w_mode == MODE_RUN) && !w_tick) ? r_div + DIV_W'(1) : '0;
      r_period <= w_advance && (w_next == r_ref);
      r_hout   <= w_seg_c;
      // Load also redefines the reference used for period detection
      if (w_mode == MODE_LOAD) begin
        r_state <= w_load_val;
        r_ref   <= w_load_val;
      end else if (w_advance) begin
        r_state <= w_next;
      end
    end
  end

  assign lfsr_out    = r_state;
  assign period_done = r_period;
  assign hout        = r_hout;

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Directed bench for lfsr_hex_display: one default instance (DIV=4,
// active-low segments) and one fast instance (DIV=1, active-high segments).
module tb_lfsr_hex_display;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        step;
  logic [7:0]  seed;
  logic [7:0]  lfsr_out;
  logic        period_done;
  logic [13:0] hout;
  logic [7:0]  lfsr_fast;
  logic        pd_fast;
  logic [13:0] hout_fast;

  int n_checks;
  int n_errors;

  lfsr_hex_display u_dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .step        (step),
    .seed        (seed),
    .lfsr_out    (lfsr_out),
    .period_done (period_done),
    .hout        (hout)
  );

  lfsr_hex_display #(
    .WIDTH      (8),
    .TAPS       (8'hB8),
    .RESET_SEED (8'h01),
    .DIV        (1),
    .ACTIVE_LOW (1'b0)
  ) u_dut_fast (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .step        (step),
    .seed        (seed),
    .lfsr_out    (lfsr_fast),
    .period_done (pd_fast),
    .hout        (hout_fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int  first_p;
  int  prev_p;
  int  n_pulses;
  int  slow_first;
  bit  zero_seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b0;
    mode = 2'b00;
    step = 1'b0;
    seed = 8'h00;

    // Reset values
    tick(1);
    check_eq("rst_lfsr", 32'(lfsr_out), 32'h01);
    check_eq("rst_pd", 32'(period_done), 32'h0);
    check_eq("rst_hout", 32'(hout), 32'h3FFF);
    check_eq("rst_hout_fast", 32'(hout_fast), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    tick(1);
    check_eq("hout_01", 32'(hout), 32'h2079);
    check_eq("hout_01_fast", 32'(hout_fast), 32'h1F86);
    tick(5);
    check_eq("hold_lfsr", 32'(lfsr_out), 32'h01);

    // Load with zero-seed guard
    mode = 2'b11; seed = 8'h00;
    tick(1);
    check_eq("load_zero", 32'(lfsr_out), 32'h01);
    seed = 8'h80;
    tick(1);
    check_eq("load_80", 32'(lfsr_out), 32'h80);
    check_eq("load_pd", 32'(period_done), 32'h0);
    mode = 2'b10;
    tick(1);
    check_eq("step_idle", 32'(lfsr_out), 32'h80);
    step = 1'b1;
    tick(1);
    check_eq("step_from_80", 32'(lfsr_out), 32'h01);
    step = 1'b0;
    tick(1);

    // Step edge: held high gives one advance only
    step = 1'b1;
    tick(10);
    check_eq("step_held", 32'(lfsr_out), 32'h02);
    step = 1'b0;
    tick(1);
    check_eq("step_release", 32'(lfsr_out), 32'h02);
    step = 1'b1;
    tick(1);
    check_eq("step_repress", 32'(lfsr_out), 32'h04);
    step = 1'b0;
    tick(1);

    // Divider: advance every 4th clock
    mode = 2'b11; seed = 8'h01;
    tick(1);
    mode = 2'b01;
    tick(3);
    check_eq("div_wait", 32'(lfsr_out), 32'h01);
    tick(1);
    check_eq("div_02", 32'(lfsr_out), 32'h02);
    tick(4);
    check_eq("div_04", 32'(lfsr_out), 32'h04);
    tick(4);
    check_eq("div_08", 32'(lfsr_out), 32'h08);
    tick(4);
    check_eq("div_11", 32'(lfsr_out), 32'h11);

    // Mode change mid-count clears the divider
    tick(2);
    mode = 2'b00;
    tick(1);
    check_eq("midcount_hold", 32'(lfsr_out), 32'h11);
    mode = 2'b01;
    tick(3);
    check_eq("midcount_wait", 32'(lfsr_out), 32'h11);
    tick(1);
    check_eq("midcount_23", 32'(lfsr_out), 32'h23);
    tick(1);
    check_eq("hout_23", 32'(hout), 32'h1230);

    // Async reset between edges
    tick(1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_lfsr", 32'(lfsr_out), 32'h01);
    check_eq("async_hout", 32'(hout), 32'h3FFF);
    check_eq("async_pd", 32'(period_done), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick(3);
    check_eq("div_restart_wait", 32'(lfsr_out), 32'h01);
    tick(1);
    check_eq("div_restart_02", 32'(lfsr_out), 32'h02);

    // Period detection on both instances
    mode = 2'b11; seed = 8'h01;
    tick(1);
    check_eq("period_load_pd", 32'(pd_fast), 32'h0);
    mode = 2'b01;
    first_p = 0; prev_p = 0; n_pulses = 0; slow_first = 0; zero_seen = 1'b0;
    for (int i = 1; i <= 1030; i++) begin
      tick(1);
      if (i == 1) check_eq("fast_first_adv", 32'(lfsr_fast), 32'h02);
      if (lfsr_fast == 8'h00 || lfsr_out == 8'h00) zero_seen = 1'b1;
      if (pd_fast) begin
        n_pulses++;
        if (n_pulses == 1) first_p = i;
        else check_eq("period_gap", 32'(i - prev_p), 32'd255);
        prev_p = i;
      end
      if (period_done && slow_first == 0) slow_first = i;
    end
    check_eq("period_first", 32'(first_p), 32'd255);
    check_eq("period_count", 32'(n_pulses), 32'd4);
    check_eq("slow_period", 32'(slow_first), 32'd1020);
    check_eq("never_zero", 32'(zero_seen), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
